// File: rtl/spi_responder.sv
// SPI mode-0 responder: 16-bit frames (R/W, 7-bit address, 8-bit data), MSB first.
// All SPI inputs are oversampled on i_clock through SYNC_STAGES-deep synchronisers.
// Optional 16x8 register file at 0x00-0x0F, built when SPI_RESPONDER_REGFILE_EN is defined.
module spi_responder #(
   parameter logic [7:0] WHOAMI_VALUE = 8'h5A,
   parameter int         SYNC_STAGES  = 2
) (
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic       i_sclk,
   input  logic       i_cs_n,
   input  logic       i_mosi,
   output logic       o_miso,
   output logic       o_miso_oe,
   output logic       o_wr_valid,
   output logic [6:0] o_wr_addr,
   output logic [7:0] o_wr_data,
   output logic       o_rd_strobe,
   output logic       o_frame_error,
   output logic       o_busy
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} state_t;

   state_t                 state, state_nx;
   logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync, flush;
   logic                   sclk_d, cs_d, armed;
   logic                   sclk_s, cs_s, mosi_s;
   logic                   sclk_rise, sclk_fall, cs_fall;
   logic [3:0]             cnt;
   logic [6:0]             sh;
   logic                   rw;
   logic [6:0]             addr;
   logic [7:0]             tx;
   logic [6:0]             rd_addr;
   logic [7:0]             rd_byte, reg_rd;
   logic                   bit_rise, rd_fire, wr_fire, err_fire;

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   // A CS fall only counts once CS has been seen high on real (post-reset) samples,
   // so a frame already in progress when reset is released is ignored.
   assign cs_fall   = armed & cs_d & ~cs_s;
   // Address byte as it stands on the 8th rising edge: bit 15 sits in sh[6].
   assign rd_addr   = {sh[5:0], mosi_s};

   // Synchronisers, edge-detect history and the post-reset arming flag
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         sclk_sync <= '0;
         cs_sync   <= '1;
         mosi_sync <= '0;
         flush     <= '0;
         sclk_d    <= 1'b0;
         cs_d      <= 1'b1;
         armed     <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_sclk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_cs_n};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_mosi};
         flush     <= {flush[SYNC_STAGES-2:0], 1'b1};
         sclk_d    <= sclk_s;
         cs_d      <= cs_s;
         armed     <= armed | (flush[SYNC_STAGES-1] & cs_s);
      end
   end

   // State register
   always_ff @(posedge i_clock) begin
      if (!i_reset) state <= IDLE;
      else          state <= state_nx;
   end

   // Next-state logic; CS always wins over a coincident SCLK edge
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (cs_fall) state_nx = ADDR;
         ADDR: if (cs_s) state_nx = IDLE;
               else if (sclk_rise && cnt == 4'd7) state_nx = DATA;
         DATA: if (cs_s) state_nx = IDLE;
               else if (sclk_rise && cnt == 4'd15) state_nx = HOLD;
         HOLD: if (cs_s) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State-decoded outputs and single-cycle event strobes
   always_comb begin
      o_busy    = (state != IDLE);
      o_miso_oe = (state != IDLE) & ~cs_s;
      bit_rise  = (state == ADDR || state == DATA) && !cs_s && sclk_rise;
      rd_fire   = bit_rise && state == ADDR && cnt == 4'd7 && sh[6];
      wr_fire   = bit_rise && state == DATA && cnt == 4'd15 && !rw;
      err_fire  = cs_s && ((state == ADDR && cnt != 4'd0) || state == DATA);
   end

`ifdef SPI_RESPONDER_REGFILE_EN
   logic [7:0] regs [16];

   // Register file: committed on the same edge that raises o_wr_valid
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
      end else if (wr_fire && addr[6:4] == 3'd0) begin
         regs[addr[3:0]] <= {sh, mosi_s};
      end
   end

   assign reg_rd = regs[rd_addr[3:0]];
`else
   assign reg_rd = 8'h00;
`endif

   // Read map
   always_comb begin
      rd_byte = 8'h00;
      if (rd_addr == 7'h78)          rd_byte = WHOAMI_VALUE;
      else if (rd_addr[6:4] == 3'd0) rd_byte = reg_rd;
   end

   // Frame datapath: shift-in, address latch, shift-out and output pulses
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         cnt           <= '0;
         sh            <= '0;
         rw            <= 1'b0;
         addr          <= '0;
         tx            <= '0;
         o_miso        <= 1'b0;
         o_wr_valid    <= 1'b0;
         o_rd_strobe   <= 1'b0;
         o_frame_error <= 1'b0;
         o_wr_addr     <= '0;
         o_wr_data     <= '0;
      end else begin
         o_wr_valid    <= wr_fire;
         o_rd_strobe   <= rd_fire;
         o_frame_error <= err_fire;
         if (state == IDLE && cs_fall) cnt <= '0;
         if (bit_rise) begin
            sh  <= {sh[5:0], mosi_s};
            cnt <= cnt + 4'd1;
         end
         if (bit_rise && state == ADDR && cnt == 4'd7) begin
            rw   <= sh[6];
            addr <= rd_addr;
            tx   <= sh[6] ? rd_byte : 8'h00;
         end
         if (wr_fire) begin
            o_wr_addr <= addr;
            o_wr_data <= {sh, mosi_s};
         end
         // MISO carries read data only while in DATA; it is held low otherwise
         if (state == DATA && !cs_s) begin
            if (sclk_fall) begin
               o_miso <= rw & tx[7];
               tx     <= {tx[6:0], 1'b0};
            end
         end else begin
            o_miso <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_spi_responder.sv
// Directed bench for spi_responder: SCLK = i_clock/8, frames driven MSB first,
// MISO sampled just before each SCLK rise. Expectations follow the build's
// SPI_RESPONDER_REGFILE_EN setting.
module tb_spi_responder;

   localparam int HALF = 4;
`ifdef SPI_RESPONDER_REGFILE_EN
   localparam bit REGF = 1'b1;
`else
   localparam bit REGF = 1'b0;
`endif

   logic       clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
   logic       o_miso, o_miso_oe, o_wr_valid, o_rd_strobe, o_frame_error, o_busy;
   logic [6:0] o_wr_addr;
   logic [7:0] o_wr_data;

   spi_responder dut (
      .i_clock(clk), .i_reset(rst_n), .i_sclk(sclk), .i_cs_n(cs_n), .i_mosi(mosi),
      .o_miso(o_miso), .o_miso_oe(o_miso_oe), .o_wr_valid(o_wr_valid),
      .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_rd_strobe(o_rd_strobe),
      .o_frame_error(o_frame_error), .o_busy(o_busy)
   );

   always #10 clk = ~clk;

   int          n_chk = 0, n_bad = 0;
   int          wr_cnt = 0, rd_cnt = 0, err_cnt = 0;
   logic [6:0]  last_addr = '0;
   logic [7:0]  last_data = '0;
   logic [15:0] miso_word;

   // Pulse monitor, sampled away from the DUT's active edge
   always @(negedge clk) begin
      if (o_wr_valid) begin
         wr_cnt++;
         last_addr = o_wr_addr;
         last_data = o_wr_data;
      end
      if (o_rd_strobe)   rd_cnt++;
      if (o_frame_error) err_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bits(input logic [15:0] w, input int first, input int count);
      for (int i = first; i > first - count; i--) begin
         mosi = w[i];
         clks(HALF);
         miso_word[i] = o_miso;
         sclk = 1'b1;
         clks(HALF);
         sclk = 1'b0;
      end
   endtask

   task automatic cs_start;
      miso_word = '0;
      cs_n = 1'b0;
      clks(HALF);
   endtask

   task automatic cs_end;
      clks(HALF);
      cs_n = 1'b1;
      clks(4 * HALF);
   endtask

   task automatic xfer(input string tag, input logic [15:0] w, input logic [15:0] exp_miso,
                       input int exp_wr, input int exp_rd);
      int w0, r0, e0;
      w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
      cs_start;
      bits(w, 15, 16);
      cs_end;
      check({tag, "_miso"}, miso_word, exp_miso);
      check({tag, "_wr"}, wr_cnt - w0, exp_wr);
      check({tag, "_rd"}, rd_cnt - r0, exp_rd);
      check({tag, "_err"}, err_cnt - e0, 0);
      check({tag, "_busy"}, o_busy, 0);
   endtask

   task automatic abort(input string tag, input logic [15:0] w, input int nbits);
      int w0, e0;
      w0 = wr_cnt; e0 = err_cnt;
      cs_start;
      bits(w, 15, nbits);
      cs_end;
      check({tag, "_err"}, err_cnt - e0, 1);
      check({tag, "_wr"}, wr_cnt - w0, 0);
   endtask

   initial begin
      int w0, r0, e0;
      clks(5);
      check("rst_ctl", {o_miso, o_miso_oe, o_wr_valid, o_rd_strobe, o_frame_error, o_busy}, 0);
      check("rst_addr", o_wr_addr, 0);
      check("rst_data", o_wr_data, 0);
      rst_n = 1'b1;
      clks(5);

      // Busy / output-enable while a frame is open
      cs_start;
      check("open_busy_oe", {o_busy, o_miso_oe}, 2'b11);
      bits(16'hF800, 15, 16);
      cs_end;
      check("whoami0_miso", miso_word, 16'h005A);

      xfer("whoami", 16'hF800, 16'h005A, 0, 1);
      xfer("wr03", 16'h037E, 16'h0000, 1, 0);
      check("wr03_addr", last_addr, 7'h03);
      check("wr03_data", last_data, 8'h7E);
      xfer("rd03", 16'h8300, REGF ? 16'h007E : 16'h0000, 0, 1);

      abort("abort5", 16'h0355, 5);
      xfer("rd03_a5", 16'h8300, REGF ? 16'h007E : 16'h0000, 0, 1);
      abort("abort15", 16'h0300, 15);
      xfer("rd03_a15", 16'h8300, REGF ? 16'h007E : 16'h0000, 0, 1);

      // Reset after 10 bits, released with CS still low
      cs_start;
      bits(16'hF800, 15, 10);
      rst_n = 1'b0;
      clks(3);
      check("midrst_ctl", {o_miso, o_miso_oe, o_busy}, 0);
      rst_n = 1'b1;
      w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
      bits(16'hF800, 5, 6);
      check("midrst_busy", o_busy, 0);
      check("midrst_miso", miso_word[5:0], 0);
      cs_end;
      check("midrst_pulses", (wr_cnt - w0) + (rd_cnt - r0) + (err_cnt - e0), 0);
      xfer("post_rst_whoami", 16'hF800, 16'h005A, 0, 1);
      xfer("post_rst_rd03", 16'h8300, 16'h0000, 0, 1);

      // Writes to WHOAMI and unmapped addresses pulse but store nothing
      xfer("wr78", 16'h78AB, 16'h0000, 1, 0);
      check("wr78_addr", last_addr, 7'h78);
      check("wr78_data", last_data, 8'hAB);
      xfer("rd78", 16'hF800, 16'h005A, 0, 1);
      xfer("wr20", 16'h2099, 16'h0000, 1, 0);
      xfer("rd20", 16'hA000, 16'h0000, 0, 1);

      xfer("wr05", 16'h05AA, 16'h0000, 1, 0);
      check("wr05_data", last_data, 8'hAA);
      xfer("rd05", 16'h8500, REGF ? 16'h00AA : 16'h0000, 0, 1);
      xfer("wr0f", 16'h0FC3, 16'h0000, 1, 0);
      xfer("rd0f", 16'h8F00, REGF ? 16'h00C3 : 16'h0000, 0, 1);
      xfer("wr10", 16'h1099, 16'h0000, 1, 0);
      check("wr10_addr", last_addr, 7'h10);
      xfer("rd10", 16'h9000, 16'h0000, 0, 1);

      // Back-to-back frames with minimum CS gap
      xfer("b2b_wr01", 16'h0111, 16'h0000, 1, 0);
      xfer("b2b_wr02", 16'h0222, 16'h0000, 1, 0);
      xfer("b2b_rd01", 16'h8100, REGF ? 16'h0011 : 16'h0000, 0, 1);
      xfer("b2b_rd02", 16'h8200, REGF ? 16'h0022 : 16'h0000, 0, 1);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
